bram_stream_ctrl: RTL and testbench

BRAM_STREAM_CTRL -- requirements
Module: bram_stream_ctrl

---
 rtl/bram_stream_ctrl.sv | 131 +++++++++++++
 tb/tb_bram_stream_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_ctrl.sv
// rtl/bram_stream_ctrl.sv - sequences an external simple dual-port BRAM as a stream FIFO with a 2-entry output stage
// Optional almost_full output is enabled by defining BRAM_STREAM_CTRL_AFULL_EN.
module bram_stream_ctrl #(
    parameter int DWIDTH       = 32,
    parameter int AWIDTH       = 10,
    parameter int AFULL_THRESH = 2**AWIDTH - 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [DWIDTH-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              bram_wen,
    output logic [AWIDTH-1:0] bram_waddr,
    output logic [DWIDTH-1:0] bram_din,
    output logic              bram_ren,
    output logic [AWIDTH-1:0] bram_raddr,
    input  logic [DWIDTH-1:0] bram_dout,
`ifdef BRAM_STREAM_CTRL_AFULL_EN
    output logic              almost_full,
`endif
    output logic [AWIDTH+1:0] fill_count
);

    localparam logic [AWIDTH:0] DEPTH = (AWIDTH+1)'(2**AWIDTH);

    if (AFULL_THRESH < 0 || AFULL_THRESH > 2**AWIDTH + 2) begin : g_bad_thresh
        $error("AFULL_THRESH outside 0..DEPTH+2");
    end

    logic [AWIDTH-1:0] wptr_q, wptr_d;
    logic [AWIDTH-1:0] rptr_q, rptr_d;
    logic [AWIDTH:0]   bram_cnt_q, bram_cnt_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        out_occ_q, out_occ_d;
    logic [DWIDTH-1:0] stage0_q, stage0_d;
    logic [DWIDTH-1:0] stage1_q, stage1_d;
    logic [AWIDTH+1:0] fill_count_q, fill_count_d;

    logic       push;
    logic       pop;
    logic       issue;
    logic [2:0] slots_used;

    // Space is judged on the registered count only, so a read this cycle frees nothing until next cycle.
    assign s_tready = !rst && (bram_cnt_q < DEPTH);
    assign m_tvalid = (out_occ_q != 2'd0);
    assign m_tdata  = stage0_q;
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;

    assign slots_used = {1'b0, out_occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue      = (bram_cnt_q != '0) && (slots_used < 3'd2);

    assign bram_wen   = push;
    assign bram_waddr = wptr_q;
    assign bram_din   = s_tdata;
    assign bram_ren   = issue;
    assign bram_raddr = rptr_q;
    assign fill_count = fill_count_q;

    always_comb begin
        wptr_d     = push  ? wptr_q + AWIDTH'(1) : wptr_q;
        rptr_d     = issue ? rptr_q + AWIDTH'(1) : rptr_q;
        bram_cnt_d = bram_cnt_q;
        if (push && !issue) begin
            bram_cnt_d = bram_cnt_q + (AWIDTH+1)'(1);
        end else if (!push && issue) begin
            bram_cnt_d = bram_cnt_q - (AWIDTH+1)'(1);
        end
        inflight_d = issue;
        out_occ_d  = out_occ_q + {1'b0, inflight_q} - {1'b0, pop};

        // Entry 0 is always the oldest; a returning read lands in the first free slot after any pop.
        stage0_d = pop ? stage1_q : stage0_q;
        stage1_d = stage1_q;
        if (inflight_q) begin
            if (out_occ_q == 2'd0 || (out_occ_q == 2'd1 && pop)) begin
                stage0_d = bram_dout;
            end else begin
                stage1_d = bram_dout;
            end
        end

        fill_count_d = {1'b0, bram_cnt_d}
                     + {{(AWIDTH+1){1'b0}}, inflight_d}
                     + {{AWIDTH{1'b0}}, out_occ_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            bram_cnt_q   <= '0;
            inflight_q   <= 1'b0;
            out_occ_q    <= 2'd0;
            stage0_q     <= '0;
            stage1_q     <= '0;
            fill_count_q <= '0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            bram_cnt_q   <= bram_cnt_d;
            inflight_q   <= inflight_d;
            out_occ_q    <= out_occ_d;
            stage0_q     <= stage0_d;
            stage1_q     <= stage1_d;
            fill_count_q <= fill_count_d;
        end
    end

`ifdef BRAM_STREAM_CTRL_AFULL_EN
    localparam logic [AWIDTH+1:0] AFULL_LVL = (AWIDTH+2)'(AFULL_THRESH);

    logic almost_full_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= (fill_count_q >= AFULL_LVL);
        end
    end

    assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_bram_stream_ctrl.sv
// tb/tb_bram_stream_ctrl.sv - directed and randomized self-checking bench for bram_stream_ctrl
module tb_bram_stream_ctrl;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          bram_wen;
    logic [AW-1:0] bram_waddr;
    logic [DW-1:0] bram_din;
    logic          bram_ren;
    logic [AW-1:0] bram_raddr;
    logic [DW-1:0] bram_dout;
    logic [AW+1:0] fill_count;
`ifdef BRAM_STREAM_CTRL_AFULL_EN
    logic          almost_full;
`endif

    bram_stream_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .AFULL_THRESH(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .bram_wen   (bram_wen),
        .bram_waddr (bram_waddr),
        .bram_din   (bram_din),
        .bram_ren   (bram_ren),
        .bram_raddr (bram_raddr),
        .bram_dout  (bram_dout),
`ifdef BRAM_STREAM_CTRL_AFULL_EN
        .almost_full(almost_full),
`endif
        .fill_count (fill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(2**AW)-1];
    always @(posedge clk) begin
        if (bram_wen) mem[bram_waddr] <= bram_din;
        if (bram_ren) bram_dout <= mem[bram_raddr];
    end

    int            n_chk = 0;
    int            n_err = 0;
    int            n_acc = 0;
    int            n_pop = 0;
    logic [DW-1:0] exp_q [$];
    logic          stall_pend = 1'b0;
    logic [DW-1:0] stall_data;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after inputs are driven at a negedge; returns at the next negedge.
    task automatic step();
        #1;
        if (stall_pend) chk("stall_stable", {m_tvalid, m_tdata}, {1'b1, stall_data});
        stall_pend = m_tvalid && !m_tready;
        stall_data = m_tdata;
        if (m_tvalid && m_tready) begin
            n_pop++;
            chk("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("sb_data", m_tdata, exp_q.pop_front());
        end
        if (s_tvalid && s_tready) begin
            exp_q.push_back(s_tdata);
            n_acc++;
        end
        @(negedge clk);
    endtask

    int            acc0;
    int            guard;
    logic [DW-1:0] v;

    initial begin
        rst      = 1'b1;
        s_tvalid = 1'b1;
        s_tdata  = 32'hDEAD_BEEF;
        m_tready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_wen", bram_wen, 0);
        chk("rst_ren", bram_ren, 0);
        chk("rst_fill", fill_count, 0);
        @(negedge clk);
        s_tvalid = 1'b0;
        rst      = 1'b0;
        #1;
        chk("post_rst_s_tready", s_tready, 1);
        @(negedge clk);

        // single word latency
        s_tvalid = 1'b1; s_tdata = 32'hA5A5_A5A5; m_tready = 1'b1;
        #1;
        chk("sw_wen", bram_wen, 1);
        chk("sw_waddr", bram_waddr, 0);
        chk("sw_din", bram_din, 32'hA5A5_A5A5);
        chk("sw_ren_n", bram_ren, 0);
        step();
        s_tvalid = 1'b0;
        #1;
        chk("sw_ren_n1", bram_ren, 1);
        chk("sw_raddr", bram_raddr, 0);
        chk("sw_fill_n1", fill_count, 1);
        chk("sw_mvalid_n1", m_tvalid, 0);
        step();
        #1;
        chk("sw_ren_n2", bram_ren, 0);
        chk("sw_mvalid_n2", m_tvalid, 0);
        step();
        #1;
        chk("sw_mvalid_n3", m_tvalid, 1);
        chk("sw_mdata_n3", m_tdata, 32'hA5A5_A5A5);
        step();
        #1;
        chk("sw_mvalid_n4", m_tvalid, 0);
        chk("sw_fill_n4", fill_count, 0);
        step();

        // fill to full with output stalled
        m_tready = 1'b0;
        acc0 = n_acc;
        v = 32'd1;
        for (int i = 0; i < 30; i++) begin
            s_tvalid = (v <= 32'd20);
            s_tdata  = v;
            step();
            if (n_acc != acc0 + int'(v) - 1) v = v + 32'd1;
        end
        chk("full_accepted", n_acc - acc0, 18);
        s_tvalid = 1'b1; s_tdata = 32'd19;
        #1;
        chk("full_s_tready", s_tready, 0);
        chk("full_wen", bram_wen, 0);
        chk("full_fill", fill_count, 18);
        chk("full_mdata", m_tdata, 1);
`ifdef BRAM_STREAM_CTRL_AFULL_EN
        chk("full_afull", almost_full, 1);
`endif
        step();
        s_tvalid = 1'b0; m_tready = 1'b1;
        n_pop = 0;
        for (int i = 0; i < 25; i++) step();
        chk("drain_pops", n_pop, 18);
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_fill", fill_count, 0);

        // sustained streaming
        n_pop = 0;
        v = 32'd1000;
        s_tvalid = 1'b1; m_tready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s_tdata = v;
            step();
            v = v + 32'd1;
        end
        chk("stream_pops", n_pop, 97);
        s_tvalid = 1'b0;
        #1;
        chk("stream_fill", fill_count, 3);
        step();
        for (int i = 0; i < 5; i++) step();
        chk("stream_empty", exp_q.size(), 0);

        // random backpressure
        acc0 = n_acc;
        n_pop = 0;
        guard = 0;
        while ((n_acc - acc0) < 5000 && guard < 40000) begin
            s_tvalid = 1'($urandom_range(0, 1));
            m_tready = 1'($urandom_range(0, 1));
            s_tdata  = $urandom;
            if ((n_acc - acc0) == 4999 && !s_tvalid) s_tdata = 32'h0;
            step();
            guard++;
        end
        chk("rand_accepted", n_acc - acc0, 5000);
        s_tvalid = 1'b0; m_tready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            step();
            guard++;
        end
        chk("rand_pops", n_pop, 5000);
        chk("rand_empty", exp_q.size(), 0);

        // reset mid-run with a read in flight
        m_tready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s_tvalid = 1'b1; s_tdata = 32'h100 + i;
            step();
        end
        s_tvalid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        #1;
        chk("mr_fill7", fill_count, 7);
        s_tvalid = 1'b1; s_tdata = 32'h107; m_tready = 1'b1;
        #1;
        chk("mr_issue", bram_ren, 1);
        step();
        #1;
        chk("mr_fill_before_rst", fill_count, 7);
        rst = 1'b1;
        s_tvalid = 1'b1; m_tready = 1'b0;
        #1;
        chk("mr_s_tready", s_tready, 0);
        chk("mr_m_tvalid", m_tvalid, 0);
        chk("mr_wen", bram_wen, 0);
        chk("mr_ren", bram_ren, 0);
        chk("mr_fill", fill_count, 0);
        exp_q.delete();
        stall_pend = 1'b0;
        s_tvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_pop = 0;
        s_tvalid = 1'b1; s_tdata = 32'h1; m_tready = 1'b1;
        step();
        s_tvalid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("mr_only_one", n_pop, 1);
        chk("mr_empty", exp_q.size(), 0);
        chk("mr_fill_end", fill_count, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
